// File: rtl/histogram_esitleme_motoru_if.sv
// rtl/histogram_esitleme_motoru_if.sv - pixel stream and mapping request/response bundle
interface histogram_esitleme_motoru_if #(
   parameter int PIXEL_BIT = 8
);
   logic                 etkin_i;
   logic [PIXEL_BIT-1:0] pixel_i;
   logic                 esle_gecerli_i;
   logic [PIXEL_BIT-1:0] esle_pixel_i;
   logic [PIXEL_BIT-1:0] pixel_o;
   logic                 pixel_gecerli_o;

   modport master (
      output etkin_i, pixel_i, esle_gecerli_i, esle_pixel_i,
      input  pixel_o, pixel_gecerli_o
   );

   modport slave (
      input  etkin_i, pixel_i, esle_gecerli_i, esle_pixel_i,
      output pixel_o, pixel_gecerli_o
   );
endinterface

// File: rtl/histogram_esitleme_motoru.sv
// rtl/histogram_esitleme_motoru.sv - histogram accumulation, cdf_min-normalised LUT build, pixel mapping
module histogram_esitleme_motoru #(
   parameter int PIXEL_BIT    = 8,
   parameter int CERCEVE_LOG2 = 16
) (
   input  logic                            clk_i,
   input  logic                            rstn_i,
   input  logic                            stal_i,
   input  logic                            bypass_i,
   histogram_esitleme_motoru_if.slave      akis,
   output logic [CERCEVE_LOG2:0]           cdf_min_o,
   output logic                            hazir_o,
   output logic                            mesgul_o,
   output logic                            hata_o
);
   localparam int L  = 1 << PIXEL_BIT;
   localparam int C  = CERCEVE_LOG2 + 1;
   localparam int NW = CERCEVE_LOG2 + PIXEL_BIT + 1;
   localparam int BW = $clog2(PIXEL_BIT + 1);

   localparam logic [C-1:0]         N_VAL   = {1'b1, {CERCEVE_LOG2{1'b0}}};
   localparam logic [C-1:0]         N_SON   = N_VAL - 1'b1;
   localparam logic [PIXEL_BIT-1:0] MAX_PIX = '1;
   localparam logic [NW-1:0]        LM1     = {{(NW-PIXEL_BIT){1'b0}}, MAX_PIX};
   localparam logic [BW-1:0]        BIT_SON = BW'(PIXEL_BIT - 1);

   typedef enum logic [1:0] {TOPLA, YUKLE, BOL, YAZ} durum_t;

   durum_t               durum;
   logic [C-1:0]         hist [L];
   logic [L-1:0]         hist_vld;
   logic [PIXEL_BIT-1:0] lut [L];
   logic [C-1:0]         sayac;
   logic [PIXEL_BIT-1:0] min_v;
   logic [PIXEL_BIT-1:0] v;
   logic [C-1:0]         cdf;
   logic [C-1:0]         cdf_min_bld;
   logic [C-1:0]         payda;
   logic [NW-1:0]        kalan;
   logic [NW-1:0]        bolen;
   logic [PIXEL_BIT-1:0] bolum;
   logic [BW-1:0]        bit_say;

   logic                 kabul;
   logic                 ilk;
   logic [C-1:0]         hist_p;
   logic [C-1:0]         artik;
   logic [PIXEL_BIT-1:0] yeni_min;
   logic [C-1:0]         hist_min;
   logic [C-1:0]         cdf_min_yeni;
   logic [C-1:0]         hist_v;
   logic [C-1:0]         cdf_yeni;
   logic [C-1:0]         fark;
   logic [NW-1:0]        pay;
   logic [PIXEL_BIT-1:0] lut_deger;
   logic [PIXEL_BIT-1:0] eslenen;

   // Histogram update, cdf_min candidate, numerator and LUT value for the current bin
   always_comb begin
      kabul        = akis.etkin_i && (durum == TOPLA);
      ilk          = (sayac == '0);
      hist_p       = hist_vld[akis.pixel_i] ? hist[akis.pixel_i] : '0;
      artik        = ilk ? C'(1) : hist_p + 1'b1;
      yeni_min     = (akis.pixel_i < min_v) ? akis.pixel_i : min_v;
      hist_min     = hist_vld[yeni_min] ? hist[yeni_min] : '0;
      // The bin being incremented this cycle may itself be the new minimum bin
      cdf_min_yeni = (yeni_min == akis.pixel_i) ? artik : hist_min;
      hist_v       = hist_vld[v] ? hist[v] : '0;
      cdf_yeni     = cdf + hist_v;
      // Bins below min_v would go negative; their LUT entry is forced to 0 anyway
      fark         = (cdf_yeni >= cdf_min_bld) ? cdf_yeni - cdf_min_bld : '0;
      pay          = {{(NW-C){1'b0}}, fark} * LM1;
      if (v < min_v)
         lut_deger = '0;
      else if (payda == '0)
         lut_deger = v;
      else
         lut_deger = bolum;
      if (bypass_i || !hazir_o)
         eslenen = akis.esle_pixel_i;
      else
         eslenen = lut[akis.esle_pixel_i];
   end

   // Histogram bins and LUT entries need no reset: validity is tracked by hist_vld and hazir_o
   always_ff @(posedge clk_i) begin
      if (!stal_i) begin
         if (kabul)
            hist[akis.pixel_i] <= artik;
         if (durum == YAZ)
            lut[v] <= lut_deger;
      end
   end

   // Control FSM: accumulate, per-bin load/divide/write, plus the registered mapping output
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         durum                <= TOPLA;
         hist_vld             <= '0;
         sayac                <= '0;
         min_v                <= MAX_PIX;
         v                    <= '0;
         cdf                  <= '0;
         cdf_min_bld          <= '0;
         payda                <= '0;
         kalan                <= '0;
         bolen                <= '0;
         bolum                <= '0;
         bit_say              <= '0;
         akis.pixel_o         <= '0;
         akis.pixel_gecerli_o <= 1'b0;
         cdf_min_o            <= '0;
         hazir_o              <= 1'b0;
         mesgul_o             <= 1'b0;
         hata_o               <= 1'b0;
      end else if (!stal_i) begin
         akis.pixel_gecerli_o <= akis.esle_gecerli_i;
         if (akis.esle_gecerli_i)
            akis.pixel_o <= eslenen;
         if (akis.etkin_i && (durum != TOPLA))
            hata_o <= 1'b1;
         case (durum)
            TOPLA: begin
               if (akis.etkin_i) begin
                  if (ilk)
                     hist_vld <= '0;
                  hist_vld[akis.pixel_i] <= 1'b1;
                  min_v <= yeni_min;
                  if (sayac == N_SON) begin
                     durum       <= YUKLE;
                     v           <= '0;
                     cdf         <= '0;
                     cdf_min_bld <= cdf_min_yeni;
                     payda       <= N_VAL - cdf_min_yeni;
                     mesgul_o    <= 1'b1;
                     hazir_o     <= 1'b0;
                  end else begin
                     sayac <= sayac + 1'b1;
                  end
               end
            end
            YUKLE: begin
               cdf     <= cdf_yeni;
               kalan   <= pay;
               // Divisor pre-aligned to the quotient MSB; shifted right once per step
               bolen   <= {1'b0, payda, {(PIXEL_BIT-1){1'b0}}};
               bit_say <= '0;
               durum   <= BOL;
            end
            BOL: begin
               if (kalan >= bolen) begin
                  kalan <= kalan - bolen;
                  bolum <= {bolum[PIXEL_BIT-2:0], 1'b1};
               end else begin
                  bolum <= {bolum[PIXEL_BIT-2:0], 1'b0};
               end
               bolen   <= bolen >> 1;
               bit_say <= bit_say + 1'b1;
               if (bit_say == BIT_SON)
                  durum <= YAZ;
            end
            YAZ: begin
               if (v == MAX_PIX) begin
                  durum     <= TOPLA;
                  sayac     <= '0;
                  min_v     <= MAX_PIX;
                  mesgul_o  <= 1'b0;
                  hazir_o   <= 1'b1;
                  cdf_min_o <= cdf_min_bld;
               end else begin
                  v     <= v + 1'b1;
                  durum <= YUKLE;
               end
            end
            default: durum <= TOPLA;
         endcase
      end
   end
endmodule

// File: tb/tb_histogram_esitleme_motoru.sv
// tb/tb_histogram_esitleme_motoru.sv - self-checking bench for histogram_esitleme_motoru
module tb_histogram_esitleme_motoru;
   localparam int PB = 8;
   localparam int CL = 4;

   logic          clk = 1'b0;
   logic          rstn;
   logic          stal;
   logic          bypass;
   logic [CL:0]   cdf_min_o;
   logic          hazir_o;
   logic          mesgul_o;
   logic          hata_o;

   int n_vec = 0;
   int n_err = 0;

   histogram_esitleme_motoru_if #(.PIXEL_BIT(PB)) akis ();

   histogram_esitleme_motoru #(.PIXEL_BIT(PB), .CERCEVE_LOG2(CL)) dut (
      .clk_i     (clk),
      .rstn_i    (rstn),
      .stal_i    (stal),
      .bypass_i  (bypass),
      .akis      (akis),
      .cdf_min_o (cdf_min_o),
      .hazir_o   (hazir_o),
      .mesgul_o  (mesgul_o),
      .hata_o    (hata_o)
   );

   always #5 clk = ~clk;

   typedef struct {
      int          grp;
      logic        byp;
      logic [7:0]  pix;
      logic [7:0]  exp;
   } vec_t;

   vec_t       tbl [16];
   logic [7:0] sb_q [$];
   logic [7:0] fr_a [16];
   logic [7:0] fr_b [16];
   logic [7:0] fr_c [16];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   // Scoreboard: every valid mapped pixel must match the oldest queued expectation
   always @(negedge clk) begin
      if (rstn && akis.pixel_gecerli_o && !stal) begin
         if (sb_q.size() == 0) begin
            chk("sb_unexpected_valid", 1, 0);
         end else begin
            chk("sb_map_pixel", akis.pixel_o, sb_q.pop_front());
         end
      end
   end

   task automatic run_grp(input int g);
      for (int i = 0; i < 16; i++) begin
         if (tbl[i].grp == g) begin
            bypass              = tbl[i].byp;
            akis.esle_gecerli_i = 1'b1;
            akis.esle_pixel_i   = tbl[i].pix;
            sb_q.push_back(tbl[i].exp);
            @(negedge clk);
         end
      end
      akis.esle_gecerli_i = 1'b0;
      bypass              = 1'b0;
      repeat (2) @(negedge clk);
      chk("sb_drained", sb_q.size(), 0);
   endtask

   task automatic send_range(input logic [7:0] px [16], input int lo, input int hi, input int stall_after);
      for (int i = lo; i <= hi; i++) begin
         if (i == stall_after) begin
            stal          = 1'b1;
            akis.etkin_i  = 1'b1;
            akis.pixel_i  = 8'd0;
            repeat (50) @(negedge clk);
            stal          = 1'b0;
            akis.etkin_i  = 1'b0;
         end
         if (i == 15 && stall_after >= 0)
            chk("stalled_pixel_not_counted", mesgul_o, 0);
         akis.etkin_i = 1'b1;
         akis.pixel_i = px[i];
         @(negedge clk);
      end
      akis.etkin_i = 1'b0;
   endtask

   task automatic wait_build(input int stall_at, input int drop_at, input int exp_cyc);
      int cnt = 0;
      chk("busy_at_start", mesgul_o, 1);
      chk("ready_low_at_start", hazir_o, 0);
      while (!hazir_o && cnt < 4000) begin
         if (cnt == stall_at)      stal = 1'b1;
         if (cnt == stall_at + 50) stal = 1'b0;
         akis.etkin_i = (cnt == drop_at);
         akis.pixel_i = 8'd0;
         @(negedge clk);
         cnt++;
      end
      stal         = 1'b0;
      akis.etkin_i = 1'b0;
      chk("build_latency", cnt, exp_cyc);
      chk("busy_at_end", mesgul_o, 0);
   endtask

   initial begin
      tbl[0]  = '{0, 1'b0, 8'd0,   8'd0};
      tbl[1]  = '{0, 1'b0, 8'd64,  8'd85};
      tbl[2]  = '{0, 1'b0, 8'd128, 8'd170};
      tbl[3]  = '{0, 1'b0, 8'd255, 8'd255};
      tbl[4]  = '{0, 1'b0, 8'd100, 8'd85};
      tbl[5]  = '{1, 1'b1, 8'd64,  8'd64};
      tbl[6]  = '{1, 1'b1, 8'd200, 8'd200};
      tbl[7]  = '{2, 1'b0, 8'd7,   8'd7};
      tbl[8]  = '{2, 1'b0, 8'd200, 8'd200};
      tbl[9]  = '{2, 1'b0, 8'd255, 8'd255};
      tbl[10] = '{3, 1'b0, 8'd5,   8'd0};
      tbl[11] = '{3, 1'b0, 8'd10,  8'd0};
      tbl[12] = '{3, 1'b0, 8'd15,  8'd0};
      tbl[13] = '{3, 1'b0, 8'd20,  8'd255};
      tbl[14] = '{3, 1'b0, 8'd25,  8'd255};
      tbl[15] = '{4, 1'b0, 8'd64,  8'd85};
      for (int i = 0; i < 16; i++) begin
         fr_a[i] = (i < 4) ? 8'd0 : (i < 8) ? 8'd64 : (i < 12) ? 8'd128 : 8'd255;
         fr_b[i] = 8'd7;
         fr_c[i] = (i % 2 == 0) ? 8'd10 : 8'd20;
      end

      rstn = 1'b0; stal = 1'b0; bypass = 1'b0;
      akis.etkin_i = 1'b0; akis.pixel_i = '0;
      akis.esle_gecerli_i = 1'b0; akis.esle_pixel_i = '0;
      repeat (3) @(negedge clk);
      chk("rst_pixel_o", akis.pixel_o, 0);
      chk("rst_pixel_gecerli_o", akis.pixel_gecerli_o, 0);
      chk("rst_cdf_min_o", cdf_min_o, 0);
      chk("rst_hazir_o", hazir_o, 0);
      chk("rst_mesgul_o", mesgul_o, 0);
      chk("rst_hata_o", hata_o, 0);
      rstn = 1'b1;
      @(negedge clk);

      akis.esle_gecerli_i = 1'b1;
      akis.esle_pixel_i   = 8'd99;
      sb_q.push_back(8'd99);
      @(negedge clk);
      akis.esle_gecerli_i = 1'b0;
      chk("no_lut_hazir_o", hazir_o, 0);
      repeat (2) @(negedge clk);

      send_range(fr_a, 0, 15, -1);
      wait_build(-1, -1, 2560);
      chk("frame_a_cdf_min", cdf_min_o, 4);
      run_grp(0);
      run_grp(1);

      send_range(fr_b, 0, 7, -1);
      chk("old_lut_hazir_kept", hazir_o, 1);
      chk("old_lut_not_busy", mesgul_o, 0);
      run_grp(4);
      send_range(fr_b, 8, 15, -1);
      wait_build(-1, -1, 2560);
      chk("frame_b_cdf_min", cdf_min_o, 16);
      run_grp(2);

      send_range(fr_c, 0, 15, -1);
      wait_build(-1, -1, 2560);
      chk("frame_c_cdf_min", cdf_min_o, 8);
      run_grp(3);

      send_range(fr_a, 0, 15, 10);
      wait_build(1000, -1, 2610);
      chk("stall_cdf_min", cdf_min_o, 4);
      chk("stall_no_error", hata_o, 0);
      run_grp(0);

      send_range(fr_c, 0, 15, -1);
      wait_build(-1, 300, 2560);
      chk("drop_sets_hata", hata_o, 1);
      chk("drop_cdf_min", cdf_min_o, 8);
      run_grp(3);
      send_range(fr_a, 0, 15, -1);
      wait_build(-1, -1, 2560);
      chk("hata_sticky", hata_o, 1);
      chk("after_drop_cdf_min", cdf_min_o, 4);
      run_grp(0);

      send_range(fr_c, 0, 15, -1);
      repeat (500) @(negedge clk);
      rstn = 1'b0;
      #1;
      chk("midrst_pixel_o", akis.pixel_o, 0);
      chk("midrst_pixel_gecerli_o", akis.pixel_gecerli_o, 0);
      chk("midrst_cdf_min_o", cdf_min_o, 0);
      chk("midrst_hazir_o", hazir_o, 0);
      chk("midrst_mesgul_o", mesgul_o, 0);
      chk("midrst_hata_o", hata_o, 0);
      @(negedge clk);
      rstn = 1'b1;
      @(negedge clk);
      send_range(fr_a, 0, 15, -1);
      wait_build(-1, -1, 2560);
      chk("post_rst_cdf_min", cdf_min_o, 4);
      run_grp(0);

      chk("sb_empty_at_end", sb_q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
